// File: rtl/fixed_point_divider_pkg.sv
// Shared types and sizing helpers for the sequential fixed-point divider.
package fixed_point_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Working numerator width: dividend with the fractional zeros appended.
   function automatic int unsigned calc_num_w(input int unsigned dividend_w,
                                              input int unsigned frac_bits);
      return dividend_w + frac_bits;
   endfunction

   // Step counter must hold N plus the guard step.
   function automatic int unsigned calc_cnt_w(input int unsigned num_w);
      return $clog2(num_w + 2);
   endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/Ack coprocessor handshake and operand/result bus for the divider.
interface fixed_point_divider_if #(
   parameter int unsigned DIVIDEND_W = 16,
   parameter int unsigned DIVISOR_W  = 16,
   parameter int unsigned QUOT_W     = 16
);
   logic                  start;
   logic                  round;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [QUOT_W-1:0]     quotient;
   logic                  div_zero;
   logic                  sat;
   logic                  busy;
   logic                  ack;

   modport master (
      output start, round, dividend, divisor,
      input  quotient, div_zero, sat, busy, ack
   );

   modport slave (
      input  start, round, dividend, divisor,
      output quotient, div_zero, sat, busy, ack
   );
endinterface

// File: rtl/fixed_point_divider_div_step.sv
// One combinational restoring-division iteration.
module div_step #(
   parameter int unsigned DIVISOR_W = 16
) (
   input  logic [DIVISOR_W:0]   rem,
   input  logic                 next_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_next_c,
   output logic                 q_bit_c
);
   localparam int unsigned REM_W = DIVISOR_W + 1;
   localparam int unsigned SH_W  = REM_W + 1;

   logic [SH_W-1:0]  shifted;
   logic [REM_W-1:0] diff;

   // Partial remainder stays below the divisor, so the shifted value fits REM_W bits.
   always_comb begin
      shifted    = {rem, next_bit};
      q_bit_c    = (shifted >= SH_W'(divisor));
      diff       = shifted[REM_W-1:0] - REM_W'(divisor);
      rem_next_c = q_bit_c ? diff : shifted[REM_W-1:0];
   end
endmodule

// File: rtl/fixed_point_divider.sv
// Sequential unsigned fixed-point divider: quotient = (dividend << FRAC_BITS) / divisor,
// with optional round-half-up and saturation, behind a Start/Ack handshake.
module fixed_point_divider
   import fixed_point_div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = 16,
   parameter int unsigned DIVISOR_W  = 16,
   parameter int unsigned FRAC_BITS  = 16,
   parameter int unsigned QUOT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   fixed_point_divider_if.slave  bus
);
   localparam int unsigned N     = calc_num_w(DIVIDEND_W, FRAC_BITS);
   localparam int unsigned CNT_W = calc_cnt_w(N);
   localparam int unsigned REM_W = DIVISOR_W + 1;
   localparam int unsigned R_W   = N + 1;

   state_t               state, state_next;
   logic [N-1:0]         num_q, num_d;
   logic [N-1:0]         qsh_q, qsh_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic [DIVISOR_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 round_q, round_d;
   logic                 guard_q, guard_d;
   logic [QUOT_W-1:0]    quot_q, quot_d;
   logic                 dz_q, dz_d;
   logic                 sat_q, sat_d;
   logic                 busy_q, busy_d;
   logic                 ack_q, ack_d;

   logic [REM_W-1:0]     step_rem;
   logic                 step_bit;
   logic [R_W-1:0]       rounded;
   logic                 ovf;

   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .rem        (rem_q),
      .next_bit   (num_q[N-1]),
      .divisor    (dvs_q),
      .rem_next_c (step_rem),
      .q_bit_c    (step_bit)
   );

   assign rounded = {1'b0, qsh_q} + R_W'(round_q & guard_q);
   assign ovf     = ((rounded >> QUOT_W) != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CALC;
         CALC:    if (cnt_q == '0) state_next = FINAL;
         FINAL:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered-output next values per state.
   always_comb begin
      num_d   = num_q;
      qsh_d   = qsh_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      round_d = round_q;
      guard_d = guard_q;
      quot_d  = quot_q;
      dz_d    = dz_q;
      sat_d   = sat_q;
      busy_d  = (state_next != IDLE);
      ack_d   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               num_d   = {bus.dividend, {FRAC_BITS{1'b0}}};
               dvs_d   = bus.divisor;
               round_d = bus.round;
               rem_d   = '0;
               qsh_d   = '0;
               guard_d = 1'b0;
               cnt_d   = CNT_W'(N);
            end
         end
         CALC: begin
            rem_d = step_rem;
            num_d = num_q << 1;
            // Final pass with cnt==0 consumes a zero bit and yields the round bit.
            if (cnt_q == '0) begin
               guard_d = step_bit;
            end else begin
               qsh_d = {qsh_q[N-2:0], step_bit};
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         FINAL: begin
            ack_d = 1'b1;
            if (dvs_q == '0) begin
               quot_d = '1;
               dz_d   = 1'b1;
               sat_d  = 1'b1;
            end else if (ovf) begin
               quot_d = '1;
               dz_d   = 1'b0;
               sat_d  = 1'b1;
            end else begin
               quot_d = rounded[QUOT_W-1:0];
               dz_d   = 1'b0;
               sat_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q   <= '0;
         qsh_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         round_q <= 1'b0;
         guard_q <= 1'b0;
         quot_q  <= '0;
         dz_q    <= 1'b0;
         sat_q   <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         num_q   <= num_d;
         qsh_q   <= qsh_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         round_q <= round_d;
         guard_q <= guard_d;
         quot_q  <= quot_d;
         dz_q    <= dz_d;
         sat_q   <= sat_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.quotient = quot_q;
   assign bus.div_zero = dz_q;
   assign bus.sat      = sat_q;
   assign bus.busy     = busy_q;
   assign bus.ack      = ack_q;
endmodule
